// File: rtl/p405s_icu_dp_regqueue_pkg.sv
// Shared definitions for the ICU datapath holding-register queue.
package p405s_icu_dp_regqueue_pkg;

    localparam int ICU_DATA_W = 32;

    typedef struct packed {
        logic valid;
        logic full;
        logic ovf;
    } q_status_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/p405s_icu_dp_regqueue_entry.sv
// One enabled storage register of the holding queue; deliberately not reset.
module p405s_icu_dp_regqueue_entry #(
    parameter int WIDTH = 32
) (
    input  logic             i_cb,
    input  logic             i_we,
    input  logic [0:WIDTH-1] i_d,
    output logic [0:WIDTH-1] o_q
);

    logic [0:WIDTH-1] r_q;

    always_ff @(posedge i_cb) begin
        if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/p405s_icu_dp_regqueue.sv
// Depth-N in-order holding register bank between fetch return and decode.
// Head entry is presented on a registered output, with push/pop/flush and overflow status.
module p405s_icu_dp_regqueue
    import p405s_icu_dp_regqueue_pkg::*;
#(
    parameter int WIDTH         = ICU_DATA_W,
    parameter int DEPTH         = 4,
    parameter bit HOLD_ON_EMPTY = 1'b0,
    localparam int CNT_W        = clog2(DEPTH + 1)
) (
    input  logic             i_cb,
    input  logic             i_rst,
    input  logic [0:WIDTH-1] i_d,
    input  logic             i_e1,
    input  logic             i_rd,
    input  logic             i_flush,
    output logic [0:WIDTH-1] o_l2,
    output logic             o_valid,
    output logic             o_full,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    localparam int               PTR_W    = clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [0:WIDTH-1] r_l2, w_l2_nxt;
    logic [0:WIDTH-1] w_entry [DEPTH];
    logic             w_valid, w_full, w_push_ok, w_pop_ok;
    q_status_t        w_status;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign w_valid   = (r_cnt != '0);
    assign w_full    = (r_cnt == FULL_CNT);
    assign w_pop_ok  = i_rd & w_valid;
    assign w_push_ok = i_e1 & (~w_full | w_pop_ok);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        p405s_icu_dp_regqueue_entry #(.WIDTH(WIDTH)) u_entry (
            .i_cb (i_cb),
            .i_we (w_push_ok & (r_wptr == PTR_W'(i))),
            .i_d  (i_d),
            .o_q  (w_entry[i])
        );
    end

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cnt_nxt  = r_cnt;
        w_ovf_nxt  = 1'b0;
        w_l2_nxt   = HOLD_ON_EMPTY ? r_l2 : '0;
        if (i_flush) begin
            w_wptr_nxt = '0;
            w_rptr_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (w_push_ok) w_wptr_nxt = ptr_inc(r_wptr);
            if (w_pop_ok)  w_rptr_nxt = ptr_inc(r_rptr);
            if (w_push_ok && !w_pop_ok)      w_cnt_nxt = r_cnt + 1'b1;
            else if (w_pop_ok && !w_push_ok) w_cnt_nxt = r_cnt - 1'b1;
            w_ovf_nxt = i_e1 & ~w_push_ok;
            // The next head may be the entry being written on this same edge.
            if (w_cnt_nxt != '0) begin
                w_l2_nxt = (w_push_ok && (w_rptr_nxt == r_wptr)) ? i_d : w_entry[w_rptr_nxt];
            end
        end
    end

    always_ff @(posedge i_cb or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_l2   <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_ovf  <= w_ovf_nxt;
            r_l2   <= w_l2_nxt;
        end
    end

    assign w_status = '{valid: w_valid, full: w_full, ovf: r_ovf};

    assign o_l2    = r_l2;
    assign o_cnt   = r_cnt;
    assign o_valid = w_status.valid;
    assign o_full  = w_status.full;
    assign o_ovf   = w_status.ovf;

endmodule
